base64_decoder: RTL and testbench

Streaming Base64 decoder, the inverse of the 6-bit-index-to-ASCII printer path. It accepts ASCII characters one per handshake and maps each to its 6-bit index using the standard A-Z, a-z, 0-9, '+', '/' alphabet. Four indices are packed into a 24-bit quantum, which is emitted as 1–3 bytes over a valid/ready output port. It sits between a character source (file reader or testbench) and byte consumers, and flags malformed input.

---
 rtl/base64_pkg.sv | 54 +++++
 rtl/base64_char_map.sv | 24 ++
 rtl/base64_decoder.sv | 158 +++++++++++++++
 tb/tb_base64_decoder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/base64_pkg.sv
// Shared Base64 decoder types, character constants and the ASCII-to-index mapping.
package base64_pkg;

  typedef enum logic [1:0] {
    StCollect = 2'd0,
    StEmit    = 2'd1,
    StErr     = 2'd2
  } state_e;

  localparam logic [7:0] PAD_CHAR   = 8'h3D;
  localparam logic [7:0] CHAR_PLUS  = 8'h2B;
  localparam logic [7:0] CHAR_SLASH = 8'h2F;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_TAB   = 8'h09;

  typedef struct packed {
    logic       is_data;
    logic       is_pad;
    logic       is_ws;
    logic [5:0] idx;
  } char_info_t;

  function automatic char_info_t map_char(input logic [7:0] c, input logic skip_ws);
    char_info_t r;
    r = '0;
    if (c >= 8'h41 && c <= 8'h5A) begin
      r.is_data = 1'b1;
      r.idx     = 6'(c - 8'h41);
    end else if (c >= 8'h61 && c <= 8'h7A) begin
      // 'a' (0x61) maps to 26
      r.is_data = 1'b1;
      r.idx     = 6'(c - 8'h47);
    end else if (c >= 8'h30 && c <= 8'h39) begin
      // '0' (0x30) maps to 52
      r.is_data = 1'b1;
      r.idx     = 6'(c + 8'h04);
    end else if (c == CHAR_PLUS) begin
      r.is_data = 1'b1;
      r.idx     = 6'd62;
    end else if (c == CHAR_SLASH) begin
      r.is_data = 1'b1;
      r.idx     = 6'd63;
    end else if (c == PAD_CHAR) begin
      r.is_pad = 1'b1;
    end else if (skip_ws &&
                 (c == CHAR_SPACE || c == CHAR_CR || c == CHAR_LF || c == CHAR_TAB)) begin
      r.is_ws = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/base64_char_map.sv
// Combinational ASCII classifier: splits a character into data/pad/whitespace and its index.
module base64_char_map
  import base64_pkg::*;
#(
  parameter int unsigned SKIP_WS = 1
) (
  input  logic [7:0] char_i,
  output logic       is_data_o,
  output logic       is_pad_o,
  output logic       is_ws_o,
  output logic [5:0] idx_o
);

  char_info_t info;

  always_comb begin
    info      = map_char(char_i, (SKIP_WS != 0));
    is_data_o = info.is_data;
    is_pad_o  = info.is_pad;
    is_ws_o   = info.is_ws;
    idx_o     = info.idx;
  end

endmodule

// File: rtl/base64_decoder.sv
// Streaming Base64 decoder: packs four 6-bit indices into a quantum and emits 1-3 bytes.
module base64_decoder
  import base64_pkg::*;
#(
  parameter int unsigned SKIP_WS = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             ctrl_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [7:0]       in_char_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [7:0]       out_byte_o,
  input  logic             out_ready_i,
  output logic             err_o,
  output logic [CNT_W-1:0] out_count_o
);

  state_e             state_q, state_d;
  logic [1:0]         pos_q, pos_d;
  logic [1:0]         pads_q, pads_d;
  logic [23:0]        quantum_q, quantum_d;
  logic [1:0]         nbytes_q, nbytes_d;
  logic [1:0]         byte_sel_q, byte_sel_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_byte_q, out_byte_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;

  logic               is_data, is_pad, is_ws;
  logic [5:0]         idx;
  logic [5:0]         slot;
  logic               accept_slot;
  logic               goto_err;

  base64_char_map #(
    .SKIP_WS (SKIP_WS)
  ) u_char_map (
    .char_i    (in_char_i),
    .is_data_o (is_data),
    .is_pad_o  (is_pad),
    .is_ws_o   (is_ws),
    .idx_o     (idx)
  );

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    pads_d      = pads_q;
    quantum_d   = quantum_q;
    nbytes_d    = nbytes_q;
    byte_sel_d  = byte_sel_q;
    out_valid_d = out_valid_q;
    out_byte_d  = out_byte_q;
    err_d       = err_q;
    out_count_d = out_count_q;
    slot        = 6'd0;
    accept_slot = 1'b0;
    goto_err    = 1'b0;

    case (state_q)
      StCollect: begin
        if (in_valid_i && !is_ws) begin
          if (is_data && pads_q == 2'd0) begin
            slot        = idx;
            accept_slot = 1'b1;
          end else if (is_pad && pos_q >= 2'd2) begin
            accept_slot = 1'b1;
            pads_d      = pads_q + 2'd1;
          end else begin
            goto_err = 1'b1;
          end
        end

        if (accept_slot) begin
          case (pos_q)
            2'd0:    quantum_d[23:18] = slot;
            2'd1:    quantum_d[17:12] = slot;
            2'd2:    quantum_d[11:6]  = slot;
            default: quantum_d[5:0]   = slot;
          endcase
          pos_d = pos_q + 2'd1;
          if (pos_q == 2'd3) begin
            state_d     = StEmit;
            out_valid_d = 1'b1;
            out_byte_d  = quantum_d[23:16];
            nbytes_d    = 2'd3 - pads_d;
            byte_sel_d  = 2'd0;
          end
        end

        if (goto_err) begin
          state_d   = StErr;
          err_d     = 1'b1;
          quantum_d = 24'd0;
          pos_d     = 2'd0;
          pads_d    = 2'd0;
        end
      end

      StEmit: begin
        if (out_ready_i) begin
          out_count_d = out_count_q + CNT_W'(1);
          if (byte_sel_q == nbytes_q - 2'd1) begin
            state_d     = StCollect;
            out_valid_d = 1'b0;
            pos_d       = 2'd0;
            pads_d      = 2'd0;
            quantum_d   = 24'd0;
          end else begin
            byte_sel_d = byte_sel_q + 2'd1;
            out_byte_d = (byte_sel_q == 2'd0) ? quantum_q[15:8] : quantum_q[7:0];
          end
        end
      end

      // StErr: drain input forever; only reset leaves this state
      default: begin
        out_valid_d = 1'b0;
        err_d       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge ctrl_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StCollect;
      pos_q       <= 2'd0;
      pads_q      <= 2'd0;
      quantum_q   <= 24'd0;
      nbytes_q    <= 2'd0;
      byte_sel_q  <= 2'd0;
      out_valid_q <= 1'b0;
      out_byte_q  <= 8'd0;
      err_q       <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      pads_q      <= pads_d;
      quantum_q   <= quantum_d;
      nbytes_q    <= nbytes_d;
      byte_sel_q  <= byte_sel_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      err_q       <= err_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready_o  = (state_q != StEmit);
  assign out_valid_o = out_valid_q;
  assign out_byte_o  = out_byte_q;
  assign err_o       = err_q;
  assign out_count_o = out_count_q;

endmodule

// File: tb/tb_base64_decoder.sv
// Directed bench for base64_decoder: table of quanta plus corner-case sequences.
module tb_base64_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        out_ready;

  logic        in_ready1, out_valid1, err1;
  logic [7:0]  out_byte1;
  logic [15:0] out_count1;

  logic        in_ready0, out_valid0, err0;
  logic [7:0]  out_byte0;
  logic [1:0]  out_count0;

  int total  = 0;
  int passed = 0;

  logic [7:0] q1[$];
  logic [7:0] q0[$];

  base64_decoder #(
    .SKIP_WS (1),
    .CNT_W   (16)
  ) dut1 (
    .ctrl_i      (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_char_i   (in_char),
    .in_ready_o  (in_ready1),
    .out_valid_o (out_valid1),
    .out_byte_o  (out_byte1),
    .out_ready_i (out_ready),
    .err_o       (err1),
    .out_count_o (out_count1)
  );

  // No whitespace skipping and a tiny counter so wrap-around is reachable
  base64_decoder #(
    .SKIP_WS (0),
    .CNT_W   (2)
  ) dut0 (
    .ctrl_i      (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_char_i   (in_char),
    .in_ready_o  (in_ready0),
    .out_valid_o (out_valid0),
    .out_byte_o  (out_byte0),
    .out_ready_i (out_ready),
    .err_o       (err0),
    .out_count_o (out_count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake will happen at the coming rising edge; inputs only change just after rising edges
  always @(negedge clk) begin
    if (rst_n && out_valid1 && out_ready) q1.push_back(out_byte1);
    if (rst_n && out_valid0 && out_ready) q0.push_back(out_byte0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_char   = 8'h00;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #3;
    q1.delete();
    q0.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Entered just after a rising edge; returns just after the accepting edge
  task automatic send_char(input logic [7:0] c);
    int  n;
    logic rdy;
    n        = 0;
    rdy      = 1'b0;
    in_valid = 1'b1;
    in_char  = c;
    while (!rdy && n < 50) begin
      @(negedge clk);
      rdy = in_ready1;
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy) check("send_timeout", 32'(n), 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n);
    int k;
    k = 0;
    while (q1.size() < n && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("byte_count", 32'(q1.size()), 32'(n));
  endtask

  typedef struct {
    logic [31:0] chars;
    int          nb;
    logic [23:0] bytes;
  } vec_t;

  vec_t tbl[10];
  int   cum;
  logic [7:0] ws_seq[7];
  logic [7:0] got;

  initial begin
    tbl[0] = '{"TWFu", 3, 24'h4D616E};
    tbl[1] = '{"TWE=", 2, 24'h4D6100};
    tbl[2] = '{"TQ==", 1, 24'h4D0000};
    tbl[3] = '{"Zm9v", 3, 24'h666F6F};
    tbl[4] = '{"YQ==", 1, 24'h610000};
    tbl[5] = '{"AAAA", 3, 24'h000000};
    tbl[6] = '{"////", 3, 24'hFFFFFF};
    tbl[7] = '{"+/+/", 3, 24'hFBFFBF};
    tbl[8] = '{"TR==", 1, 24'h4D0000};
    tbl[9] = '{"MTIz", 3, 24'h313233};

    do_reset();
    check("rst_out_valid", out_valid1, 1'b0);
    check("rst_out_byte", out_byte1, 8'h00);
    check("rst_err", err1, 1'b0);
    check("rst_out_count", out_count1, 16'd0);
    check("rst_in_ready", in_ready1, 1'b1);

    // Concatenated quanta, consumer always ready
    cum = 0;
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < 4; i++) begin
        if (i == 3) check("pre_last_out_valid", out_valid1, 1'b0);
        send_char(tbl[v].chars[31-8*i -: 8]);
      end
      check("first_byte_latency", out_valid1, 1'b1);
      wait_bytes(tbl[v].nb);
      for (int j = 0; j < tbl[v].nb; j++) begin
        got = (q1.size() > 0) ? q1.pop_front() : 8'hxx;
        check("vec_byte", got, tbl[v].bytes[23-8*j -: 8]);
        got = (q0.size() > 0) ? q0.pop_front() : 8'hxx;
        check("vec_byte_noskip", got, tbl[v].bytes[23-8*j -: 8]);
      end
      cum += tbl[v].nb;
      check("vec_in_ready", in_ready1, 1'b1);
      check("vec_out_valid", out_valid1, 1'b0);
      check("vec_out_count", out_count1, 32'(cum));
      check("vec_count_wrap", out_count0, 32'(cum % 4));
    end
    check("table_err", err1, 1'b0);

    // Whitespace skipped by one instance, fatal to the other
    do_reset();
    ws_seq = '{8'h54, 8'h20, 8'h51, 8'h0D, 8'h0A, 8'h3D, 8'h3D};
    for (int i = 0; i < 7; i++) begin
      send_char(ws_seq[i]);
      if (i == 1) check("noskip_err_at_space", err0, 1'b1);
    end
    wait_bytes(1);
    got = (q1.size() > 0) ? q1.pop_front() : 8'hxx;
    check("ws_byte", got, 8'h4D);
    check("ws_err", err1, 1'b0);
    check("ws_count", out_count1, 16'd1);
    check("noskip_no_output", 32'(q0.size()), 32'd0);
    check("noskip_count", out_count0, 2'd0);
    check("noskip_in_ready", in_ready0, 1'b1);

    // Bad character mid-quantum
    do_reset();
    send_char("T");
    send_char("W");
    check("pre_bad_err", err1, 1'b0);
    send_char("*");
    check("bad_err_same_edge", err1, 1'b1);
    send_char("u");
    send_char("A");
    send_char("A");
    send_char("A");
    repeat (4) @(posedge clk);
    #1;
    check("err_in_ready", in_ready1, 1'b1);
    check("err_out_valid", out_valid1, 1'b0);
    check("err_no_bytes", 32'(q1.size()), 32'd0);
    check("err_count", out_count1, 16'd0);
    check("err_sticky", err1, 1'b1);
    // Pad too early is also an error
    do_reset();
    check("err_cleared", err1, 1'b0);
    send_char("T");
    send_char("=");
    check("early_pad_err", err1, 1'b1);
    do_reset();
    send_char("T");
    send_char("Q");
    send_char("=");
    send_char("A");
    check("data_after_pad_err", err1, 1'b1);

    // Consumer stall
    do_reset();
    out_ready = 1'b0;
    send_char("T");
    send_char("W");
    send_char("F");
    send_char("u");
    check("stall_first_valid", out_valid1, 1'b1);
    check("stall_first_byte", out_byte1, 8'h4D);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("stall_hold_byte", out_byte1, 8'h4D);
      check("stall_hold_valid", out_valid1, 1'b1);
      check("stall_in_ready", in_ready1, 1'b0);
    end
    out_ready = 1'b1;
    wait_bytes(3);
    for (int j = 0; j < 3; j++) begin
      got = (q1.size() > 0) ? q1.pop_front() : 8'hxx;
      check("stall_drain", got, tbl[0].bytes[23-8*j -: 8]);
    end
    check("stall_count", out_count1, 16'd3);

    // Reset mid-EMIT, then mid-quantum
    out_ready = 1'b0;
    send_char("M");
    send_char("T");
    send_char("I");
    send_char("z");
    check("pre_rst_valid", out_valid1, 1'b1);
    do_reset();
    check("midemit_rst_valid", out_valid1, 1'b0);
    check("midemit_rst_count", out_count1, 16'd0);
    send_char("T");
    send_char("W");
    do_reset();
    send_char("T");
    send_char("W");
    send_char("F");
    send_char("u");
    wait_bytes(3);
    for (int j = 0; j < 3; j++) begin
      got = (q1.size() > 0) ? q1.pop_front() : 8'hxx;
      check("midrst_byte", got, tbl[0].bytes[23-8*j -: 8]);
    end
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_extra", 32'(q1.size()), 32'd0);
    check("midrst_count", out_count1, 16'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
